axi_wdma_sched: RTL
===================

# axi_wdma_sched

Round-robin command and stream scheduler that shares one `axi_wdma` write-DMA engine between `NUM_REQ` requesters in the e1000 block, for example RX packet data and descriptor write-back. It grants one requester at a time and forwards that requester's command to the engine. It then routes the requester's data stream until `tlast`, waits for the engine to report idle, and pulses a per-requester done strobe. It sits directly in front of `axi_wdma`'s `cmd_*` and `din_*` ports.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal 2..4.
- `ADDRESS_BITS`, default 32: command address width.
- `LENGTH_BITS`, default 32: command byte-count width.
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_cmd_address` in NUM_REQ*ADDRESS_BITS: per-requester byte address; requester i occupies slice i.
- `s_cmd_bytes` in NUM_REQ*LENGTH_BITS: per-requester byte count.
- `s_cmd_valid` in NUM_REQ: command request.
- `s_cmd_ready` out NUM_REQ: command accepted.
- `s_tdata` in NUM_REQ*32, `s_tkeep` in NUM_REQ*4, `s_tlast` in NUM_REQ, `s_tvalid` in NUM_REQ: per-requester write streams.
- `s_tready` out NUM_REQ: per-requester stream ready.
- `s_done` out NUM_REQ: one-cycle pulse when requester i's transfer has fully completed (B response received).
- `m_cmd_address` out ADDRESS_BITS, `m_cmd_bytes` out LENGTH_BITS, `m_cmd_valid` out 1: connect to engine `cmd_*`.
- `m_cmd_ready` in 1: engine `cmd_ready`. Engine is idle when this is 1; it goes 0 the cycle after acceptance and returns to 1 on completion.
- `m_tdata` out 32, `m_tkeep` out 4, `m_tlast` out 1, `m_tvalid` out 1: connect to engine `din_*`.
- `m_tready` in 1: engine `din_tready`.
- `busy` out 1: state is not S_IDLE.
- `grant` out 2: index of the current or last granted requester.

## Operation
- States:
  - S_IDLE: waiting for a request.
  - S_CMD: presenting the granted command to the engine.
  - S_DATA: routing the granted stream.
  - S_DONE: waiting for the engine to return to idle.
- S_IDLE: if any `s_cmd_valid` bit is set, pick the first set bit searching from `grant+1` upward, modulo NUM_REQ. Register it into `grant` and go to S_CMD. Otherwise stay.
- S_CMD:
  - `m_cmd_*` = granted slice; `m_cmd_valid` = `s_cmd_valid[grant]`.
  - `s_cmd_ready[grant]` = `m_cmd_ready`; all other `s_cmd_ready` bits are 0.
  - On the handshake, latch `zero = (s_cmd_bytes[grant]==0)`. Go to S_DONE if `zero`, else S_DATA.
  - A requester may not drop `s_cmd_valid` before the handshake. If it does, stay in S_CMD.
- S_DATA:
  - `m_t*` = granted slice; `m_tvalid` = `s_tvalid[grant]`.
  - `s_tready[grant]` = `m_tready`; all other `s_tready` bits are 0.
  - On `m_tvalid && m_tready && m_tlast`, go to S_DONE.
- S_DONE: when `m_cmd_ready==1`, pulse `s_done[grant]` for one cycle and go to S_IDLE.
- Outside S_CMD, `m_cmd_valid`=0 and all `s_cmd_ready`=0.
- Outside S_DATA, `m_tvalid`=0 and all `s_tready`=0. Non-granted streams are always stalled.
- `m_cmd_*` payload and `m_t*` payload outputs are muxed from `grant` in every state. Their values are don't-care while the matching valid is 0.
- Zero-byte command: the requester must not send stream data. The block never enters S_DATA for it; `s_done` is still pulsed.
- Fairness: after requester i is served, i has lowest priority at the next arbitration.

## Timing
- Reset values: state=S_IDLE, `grant`=NUM_REQ-1 (so requester 0 wins first), `s_done`=0, `busy`=0, `m_cmd_valid`=0, `m_tvalid`=0, all `s_cmd_ready`=0, all `s_tready`=0.
- All handshake outputs are combinational from the registered state/`grant` and the inputs. No added stream latency; zero bubbles between beats.
- Request latency: `s_cmd_valid` rises in cycle 0 with the block in S_IDLE. `m_cmd_valid` is high in cycle 1.
- S_DONE entered from S_CMD: one cycle after acceptance, when the engine has already dropped `m_cmd_ready`, so no false completion.
- `s_done` is registered and asserts the cycle after `m_cmd_ready` is seen high in S_DONE, coinciding with S_IDLE. Arbitration in that same S_IDLE cycle is allowed. Back-to-back grant gap is 2 cycles.
- Reset mid-transfer: all outputs return to reset values immediately and asynchronously. No `s_done` is pulsed for the aborted requester.
- If `s_cmd_valid` requests arrive simultaneously, exactly one is granted per arbitration.

## Test plan
- Single request: req0 sends addr 0x1000, 8 bytes, 2 beats with `tlast` on beat 2. Expect `m_cmd_valid` in cycle 1, 2 beats forwarded, then `s_done[0]` one cycle after the engine's `cmd_ready` returns high; `s_done[1]` stays 0.
- Contention: req0 and req1 assert together from reset. Expect order req0, req1, req0, req1 across 4 transfers; the stalled requester sees `s_tready`=0 throughout.
- Zero length: req1 sends bytes=0. Expect `m_cmd_valid` handshake, no `m_tvalid`, and `s_done[1]` after the engine returns idle.
- Backpressure: `m_tready` toggles 1,0,0,1 during a 3-beat stream. Expect data beats unchanged and in order, and S_DATA exits only on the `tlast` handshake.
- Reset during S_DATA: `aresetn` low for 1 cycle at beat 2. Expect all outputs at reset values, `grant`=NUM_REQ-1, and no `s_done` pulse.
- NUM_REQ=4, requests 1 and 3 pending with `grant`=1. Expect requester 3 granted next, then requester 1.

Source files
------------

// File: rtl/axi_wdma_sched.sv
// Round-robin scheduler sharing one axi_wdma engine between NUM_REQ requesters.
// Grants one requester, forwards its command and stream, then waits for engine idle.
module axi_wdma_sched #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned LENGTH_BITS  = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_REQ*ADDRESS_BITS-1:0]   s_cmd_address,
    input  logic [NUM_REQ*LENGTH_BITS-1:0]    s_cmd_bytes,
    input  logic [NUM_REQ-1:0]                s_cmd_valid,
    output logic [NUM_REQ-1:0]                s_cmd_ready,
    input  logic [NUM_REQ*32-1:0]             s_tdata,
    input  logic [NUM_REQ*4-1:0]              s_tkeep,
    input  logic [NUM_REQ-1:0]                s_tlast,
    input  logic [NUM_REQ-1:0]                s_tvalid,
    output logic [NUM_REQ-1:0]                s_tready,
    output logic [NUM_REQ-1:0]                s_done,
    output logic [ADDRESS_BITS-1:0]           m_cmd_address,
    output logic [LENGTH_BITS-1:0]            m_cmd_bytes,
    output logic                              m_cmd_valid,
    input  logic                              m_cmd_ready,
    output logic [31:0]                       m_tdata,
    output logic [3:0]                        m_tkeep,
    output logic                              m_tlast,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              busy,
    output logic [1:0]                        grant
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t               state;
    logic [1:0]           next_grant;
    logic                 req_any;
    logic                 sel_cmd_valid;
    logic                 sel_tvalid;
    logic [NUM_REQ-1:0]   done_onehot;
    logic                 cmd_fire;
    logic                 last_fire;
    logic                 zero_len;

    // Search starts one past the current grant so the last served requester ranks lowest.
    always_comb begin
        next_grant = grant;
        req_any    = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!req_any && s_cmd_valid[i] && i == (32'(grant) + k) % NUM_REQ) begin
                    next_grant = 2'(i);
                    req_any    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        m_cmd_address = '0;
        m_cmd_bytes   = '0;
        m_tdata       = '0;
        m_tkeep       = '0;
        m_tlast       = 1'b0;
        sel_cmd_valid = 1'b0;
        sel_tvalid    = 1'b0;
        s_cmd_ready   = '0;
        s_tready      = '0;
        done_onehot   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == 2'(i)) begin
                m_cmd_address  = s_cmd_address[i*ADDRESS_BITS +: ADDRESS_BITS];
                m_cmd_bytes    = s_cmd_bytes[i*LENGTH_BITS +: LENGTH_BITS];
                m_tdata        = s_tdata[i*32 +: 32];
                m_tkeep        = s_tkeep[i*4 +: 4];
                m_tlast        = s_tlast[i];
                sel_cmd_valid  = s_cmd_valid[i];
                sel_tvalid     = s_tvalid[i];
                s_cmd_ready[i] = (state == S_CMD) && m_cmd_ready;
                s_tready[i]    = (state == S_DATA) && m_tready;
                done_onehot[i] = 1'b1;
            end
        end
        m_cmd_valid = (state == S_CMD) && sel_cmd_valid;
        m_tvalid    = (state == S_DATA) && sel_tvalid;
        cmd_fire    = m_cmd_valid && m_cmd_ready;
        last_fire   = m_tvalid && m_tready && m_tlast;
        zero_len    = (m_cmd_bytes == '0);
        busy        = (state != S_IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= S_IDLE;
            grant  <= 2'(NUM_REQ - 1);
            s_done <= '0;
        end else begin
            s_done <= '0;
            unique case (state)
                S_IDLE: begin
                    if (req_any) begin
                        grant <= next_grant;
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (cmd_fire)
                        state <= zero_len ? S_DONE : S_DATA;
                end
                S_DATA: begin
                    if (last_fire)
                        state <= S_DONE;
                end
                S_DONE: begin
                    // Engine drops cmd_ready the cycle after acceptance, so high here means finished.
                    if (m_cmd_ready) begin
                        s_done <= done_onehot;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
